iowrite_ctrl: RTL and testbench

Write-side I/O block, the output counterpart of the switch read path. Takes store cycles from memorio and latches data into an LED register and a 16-bit seven-segment value register. Continuously time-multiplexes the seven-segment value as 4 hex digits on a common-anode display. Sits between memorio and the board LED and segment pins.

---
 rtl/iowrite_pkg.sv | 41 ++++
 rtl/seg_hex_decoder.sv | 14 +
 rtl/iowrite_ctrl.sv | 132 +++++++++++++
 tb/tb_iowrite_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/iowrite_pkg.sv
// Shared definitions for the I/O write path: write-target decode, LED address
// map, display idle values and the common-anode hex segment table.
package iowrite_pkg;

  localparam logic [1:0] LED_LO_ADDR = 2'b00;
  localparam logic [1:0] LED_HI_ADDR = 2'b10;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] HEX_SEG [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    WR_NONE,
    WR_LED_LO,
    WR_LED_HI,
    WR_SEG
  } wr_target_e;

  // Selecting both devices at once is a decode error and writes nothing;
  // LED writes to the odd addresses are silently ignored.
  function automatic wr_target_e decode_write(input logic       iow,
                                              input logic       ledctrl,
                                              input logic       segctrl,
                                              input logic [1:0] addr_lo);
    wr_target_e target;
    target = WR_NONE;
    if (iow && ledctrl && !segctrl) begin
      if (addr_lo == LED_LO_ADDR)      target = WR_LED_LO;
      else if (addr_lo == LED_HI_ADDR) target = WR_LED_HI;
    end else if (iow && segctrl && !ledctrl) begin
      target = WR_SEG;
    end
    return target;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg_hex_decoder
  import iowrite_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  // Straight table lookup; the table already carries dp=1 (off).
  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/iowrite_ctrl.sv
// Write-side I/O block: latches store data from memorio into the LED register
// and the 16-bit seven-segment value register, acknowledges each accepted
// write, and scans the value as four hex digits on a common-anode display.
// Optional build macro IOWRITE_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (digit 0 is always shown).
module iowrite_ctrl
  import iowrite_pkg::*;
#(
  parameter int LED_WIDTH = 24,
  parameter int SCAN_DIV  = 100000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iow,
  input  logic                 ledctrl,
  input  logic                 segctrl,
  input  logic [1:0]           addr_lo,
  input  logic [15:0]          iowrite_data,
  output logic [LED_WIDTH-1:0] led,
  output logic [3:0]           seg_an,
  output logic [7:0]           seg_out,
  output logic                 write_ack
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  wr_target_e           wr_target;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [15:0]          seg_value_q, seg_value_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0]           seg_an_q, seg_an_d;
  logic [7:0]           seg_out_q, seg_out_d;
  logic                 write_ack_q, write_ack_d;
  logic [3:0]           cur_nibble;
  logic [7:0]           hex_seg;
  logic                 blank;

  // Classify the store cycle presented this clock.
  always_comb begin
    wr_target = decode_write(iow, ledctrl, segctrl, addr_lo);
  end

  // Register updates for accepted writes; ack follows one cycle later.
  always_comb begin
    led_d       = led_q;
    seg_value_d = seg_value_q;
    write_ack_d = (wr_target != WR_NONE);
    case (wr_target)
      WR_LED_LO: led_d[15:0]           = iowrite_data;
      WR_LED_HI: led_d[LED_WIDTH-1:16] = iowrite_data[LED_WIDTH-17:0];
      WR_SEG:    seg_value_d           = iowrite_data;
      default:   ;
    endcase
  end

  // Dwell counter; advancing the digit on the terminal count.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Pick the nibble for the digit currently being scanned.
  always_comb begin
    case (idx_q)
      2'd0:    cur_nibble = seg_value_q[3:0];
      2'd1:    cur_nibble = seg_value_q[7:4];
      2'd2:    cur_nibble = seg_value_q[11:8];
      default: cur_nibble = seg_value_q[15:12];
    endcase
  end

  seg_hex_decoder u_hex (
    .nibble (cur_nibble),
    .seg    (hex_seg)
  );

`ifdef IOWRITE_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    case (idx_q)
      2'd0:    blank = 1'b0;
      2'd1:    blank = (seg_value_q[15:4] == 12'd0);
      2'd2:    blank = (seg_value_q[15:8] == 8'd0);
      default: blank = (seg_value_q[15:12] == 4'd0);
    endcase
  end
`else
  // All four digits are always shown.
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Next values for the registered display outputs.
  always_comb begin
    seg_an_d  = ~(4'b0001 << idx_q);
    seg_out_d = blank ? SEG_BLANK : hex_seg;
  end

  // All state, with reset taking priority over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q       <= '0;
      seg_value_q <= '0;
      div_q       <= '0;
      idx_q       <= '0;
      seg_an_q    <= AN_OFF;
      seg_out_q   <= SEG_BLANK;
      write_ack_q <= 1'b0;
    end else begin
      led_q       <= led_d;
      seg_value_q <= seg_value_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      seg_an_q    <= seg_an_d;
      seg_out_q   <= seg_out_d;
      write_ack_q <= write_ack_d;
    end
  end

  assign led       = led_q;
  assign seg_an    = seg_an_q;
  assign seg_out   = seg_out_q;
  assign write_ack = write_ack_q;

endmodule

// File: tb/tb_iowrite_ctrl.sv
// Directed bench for iowrite_ctrl with LED_WIDTH=24, SCAN_DIV=4. Each driven
// cycle pushes the expected post-edge outputs from a behavioural model into a
// scoreboard queue, which is popped and compared once the edge has happened.
module tb_iowrite_ctrl;

  localparam int LED_WIDTH = 24;
  localparam int SCAN_DIV  = 4;

  typedef struct {
    string                tag;
    logic [LED_WIDTH-1:0] led;
    logic [3:0]           an;
    logic [7:0]           out;
    logic                 ack;
  } expect_t;

  logic                 clock;
  logic                 reset;
  logic                 iow;
  logic                 ledctrl;
  logic                 segctrl;
  logic [1:0]           addrLo;
  logic [15:0]          iowriteData;
  logic [LED_WIDTH-1:0] led;
  logic [3:0]           segAn;
  logic [7:0]           segOut;
  logic                 writeAck;

  expect_t     sbQueue[$];
  int          testCount = 0;
  int          failCount = 0;

  logic [LED_WIDTH-1:0] mLed;
  logic [15:0]          mSeg;
  int                   mCycles;

  logic [7:0] hexTable [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  iowrite_ctrl #(
    .LED_WIDTH (LED_WIDTH),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iow          (iow),
    .ledctrl      (ledctrl),
    .segctrl      (segctrl),
    .addr_lo      (addrLo),
    .iowrite_data (iowriteData),
    .led          (led),
    .seg_an       (segAn),
    .seg_out      (segOut),
    .write_ack    (writeAck)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison of an observed DUT value against a bench-derived value.
  task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic checkOutput();
    expect_t e;
    if (sbQueue.size() == 0) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sbQueue.pop_front();
      checkField({e.tag, ".led"},  32'(led),      32'(e.led));
      checkField({e.tag, ".an"},   32'(segAn),    32'(e.an));
      checkField({e.tag, ".out"},  32'(segOut),   32'(e.out));
      checkField({e.tag, ".ack"},  32'(writeAck), 32'(e.ack));
    end
  endtask

  // Drive one cycle, predict the outputs after the edge, then check them.
  task automatic applyStimulus(input logic rst, input logic w, input logic lc, input logic sc,
                               input logic [1:0] a, input logic [15:0] d, input string tag);
    expect_t     e;
    logic [15:0] oldSeg;
    logic [15:0] shifted;
    int          digit;
    logic        acc;
    reset = rst; iow = w; ledctrl = lc; segctrl = sc; addrLo = a; iowriteData = d;
    e.tag = tag;
    if (rst) begin
      mLed = '0; mSeg = '0; mCycles = 0;
      e.an = 4'hF; e.out = 8'hFF; e.ack = 1'b0;
    end else begin
      oldSeg = mSeg;
      mCycles++;
      digit = ((mCycles - 1) / SCAN_DIV) % 4;
      e.an = 4'hF;
      e.an[digit] = 1'b0;
      shifted = oldSeg >> (4 * digit);
      e.out = hexTable[shifted[3:0]];
`ifdef IOWRITE_LEADING_ZERO_BLANK_EN
      if (digit != 0 && shifted == 16'd0) e.out = 8'hFF;
`endif
      acc = 1'b0;
      if (w && lc && !sc && a == 2'b00) begin mLed[15:0] = d; acc = 1'b1; end
      if (w && lc && !sc && a == 2'b10) begin mLed[23:16] = d[7:0]; acc = 1'b1; end
      if (w && sc && !lc) begin mSeg = d; acc = 1'b1; end
      e.ack = acc;
    end
    e.led = mLed;
    sbQueue.push_back(e);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, tag);
  endtask

  initial begin
    logic [3:0] scanAn  [4];
    logic [7:0] scanOut [4];
    logic [7:0] blankOut[4];
    int         guard;
    int         digit;
    scanAn  = '{4'hE, 4'hD, 4'hB, 4'h7};
    scanOut = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
`ifdef IOWRITE_LEADING_ZERO_BLANK_EN
    blankOut = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
`else
    blankOut = '{8'hC0, 8'hB0, 8'hC0, 8'hC0};
`endif
    reset = 1'b1; iow = 1'b0; ledctrl = 1'b0; segctrl = 1'b0; addrLo = 2'b00; iowriteData = 16'h0;
    mLed = '0; mSeg = '0; mCycles = 0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, "reset");
    checkField("resetLed", 32'(led), 32'h0);
    checkField("resetAn", 32'(segAn), 32'hF);
    checkField("resetOut", 32'(segOut), 32'hFF);
    idle("firstDigit");
    checkField("firstAn", 32'(segAn), 32'hE);
    checkField("firstOut", 32'(segOut), 32'hC0);

    // LED writes and an ignored address.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'hA5A5, "ledLo");
    checkField("ledLoValue", 32'(led), 32'h00A5A5);
    checkField("ledLoAck", 32'(writeAck), 32'h1);
    idle("ledLoAckDrop");
    checkField("ledLoAckPulse", 32'(writeAck), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 16'h00FF, "ledHi");
    checkField("ledHiValue", 32'(led), 32'hFFA5A5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'h1234, "ledOdd");
    checkField("ledOddValue", 32'(led), 32'hFFA5A5);
    checkField("ledOddAck", 32'(writeAck), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'h5A5A, "b2bA");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'h4321, "b2bB");
    checkField("b2bAck", 32'(writeAck), 32'h1);

    // Scan sequence from a fresh phase.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, "scanReset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h12AF, "scanWrite");
    for (int k = 2; k <= 17; k++) begin
      idle("scan");
      digit = ((k - 1) / SCAN_DIV) % 4;
      checkField("scanAnStep", 32'(segAn), 32'(scanAn[digit]));
      checkField("scanOutStep", 32'(segOut), 32'(scanOut[digit]));
    end

    // Decode conflict and iow low must change nothing.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'hFFFF, "conflict");
    checkField("conflictAck", 32'(writeAck), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 16'hFFFF, "iowLow");
    for (int k = 0; k < 16; k++) idle("postConflict");

    // Reset mid-scan on digit 2 with a simultaneous seg write.
    guard = 0;
    while (((mCycles - 1) / SCAN_DIV) % 4 != 2 && guard < 40) begin
      idle("seekDigit2");
      guard++;
    end
    checkField("onDigit2", 32'(segAn), 32'hB);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'hBEEF, "resetMidScan");
    for (int k = 1; k <= SCAN_DIV; k++) begin
      idle("restart");
      checkField("restartAn", 32'(segAn), 32'hE);
      checkField("restartOut", 32'(segOut), 32'hC0);
    end
    idle("restartNext");
    checkField("restartNextAn", 32'(segAn), 32'hD);
    for (int k = 0; k < 12; k++) idle("restartScan");

    // Leading-digit behaviour with a small value, then with zero.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, "lzReset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0030, "lzWrite");
    for (int k = 2; k <= 16; k++) begin
      idle("lz");
      digit = ((k - 1) / SCAN_DIV) % 4;
      checkField("lzOut", 32'(segOut), 32'(blankOut[digit]));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000, "zeroWrite");
    for (int k = 0; k < 16; k++) idle("zeroScan");
    checkField("zeroDigit0", 32'(segOut), 32'hC0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
